// File: rtl/gcd_countdown_n_if.sv
// Button/display bundle for gcd_countdown_n: edit controls in, display and status out.
interface gcd_countdown_n_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned SELW  = 2
);
    logic [SELW-1:0]  select;
    logic             add;
    logic             sub;
    logic             next;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic [1:0]       state_out;
    logic             busy;
    logic             done;

    modport master (
        output select, add, sub, next, data_in,
        input  data_out, state_out, busy, done
    );

    modport slave (
        input  select, add, sub, next, data_in,
        output data_out, state_out, busy, done
    );
endinterface

// File: rtl/gcd_countdown_n.sv
// N-channel modular digit accumulator with sequential GCD search, reduce-by-GCD
// and a visible tick-paced countdown of the GCD.
module gcd_countdown_n #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned RADIX    = 10,
    parameter int unsigned TICK     = 50_000_000,
    parameter int unsigned SELW     = $clog2(CHANNELS)
) (
    input  logic             clk,
    input  logic             rst_n,
    gcd_countdown_n_if.slave bus
);

    localparam int unsigned EW = WIDTH + 1;
    localparam int unsigned TW = (TICK > 1) ? $clog2(TICK) : 1;
    localparam logic [EW-1:0]    RADIX_E   = EW'(RADIX);
    localparam logic [WIDTH-1:0] C_START   = WIDTH'(RADIX - 1);
    localparam logic [TW-1:0]    TICK_LAST = TW'(TICK - 1);

    typedef enum logic [1:0] {
        SETUP = 2'd0,
        CALC  = 2'd1,
        SHOW  = 2'd2,
        COUNT = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ch_q [CHANNELS];
    logic [WIDTH-1:0] ch_d [CHANNELS];
    logic [WIDTH-1:0] gcd_q, gcd_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [TW-1:0]    tick_q, tick_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             busy_q, done_q, done_d;
    logic             add_h, sub_h, next_h;
    logic             add_ev, sub_ev, next_ev;

    logic [EW-1:0]    op_e, cur_e;
    logic [WIDTH-1:0] div, div_safe, gdiv;
    logic             all_div, all_zero;
    logic [WIDTH-1:0] sel_new;

    assign add_ev  = bus.add  & ~add_h;
    assign sub_ev  = bus.sub  & ~sub_h;
    assign next_ev = bus.next & ~next_h;
    assign op_e    = {1'b0, bus.data_in} % RADIX_E;

    assign bus.data_out  = data_out_q;
    assign bus.state_out = state_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

    // Shared divisibility test: the CALC candidate, or the live gcd otherwise.
    always_comb begin
        div      = (state_q == CALC) ? cand_q : gcd_q;
        div_safe = (div == '0) ? WIDTH'(1) : div;
        all_div  = 1'b1;
        all_zero = 1'b1;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if ((ch_q[i] % div_safe) != '0) all_div  = 1'b0;
            if (ch_q[i] != '0)              all_zero = 1'b0;
        end
    end

    // Next-state, buffer, gcd and counter update.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        gcd_d   = gcd_q;
        cand_d  = cand_q;
        tick_d  = tick_q;
        done_d  = 1'b0;
        cur_e   = '0;

        case (state_q)
            SETUP: begin
                if (add_ev != sub_ev) begin
                    for (int i = 0; i < int'(CHANNELS); i++) begin
                        if (bus.select == SELW'(i)) begin
                            cur_e = {1'b0, ch_q[i]};
                            if (add_ev) ch_d[i] = WIDTH'((cur_e + op_e) % RADIX_E);
                            else        ch_d[i] = WIDTH'((cur_e + RADIX_E - op_e) % RADIX_E);
                        end
                    end
                end
                if (next_ev) begin
                    state_d = CALC;
                    cand_d  = C_START;
                end
            end

            CALC: begin
                if (all_zero) begin
                    gcd_d   = '0;
                    state_d = SHOW;
                end else if (all_div) begin
                    gcd_d   = cand_q;
                    state_d = SHOW;
                end else begin
                    cand_d = cand_q - WIDTH'(1);
                end
            end

            SHOW: begin
                if (next_ev) begin
                    if (gcd_q != '0) begin
                        state_d = COUNT;
                        tick_d  = '0;
                    end else begin
                        state_d = SETUP;
                    end
                end else if (add_ev && (gcd_q > WIDTH'(1))) begin
                    for (int i = 0; i < int'(CHANNELS); i++) ch_d[i] = ch_q[i] / gcd_q;
                    gcd_d = WIDTH'(1);
                end
            end

            COUNT: begin
                // Early exit takes priority and is judged on the pre-decrement gcd.
                if (next_ev && (gcd_q != '0) && all_div) begin
                    state_d = SETUP;
                end else if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    if (gcd_q == WIDTH'(1)) begin
                        gcd_d   = '0;
                        done_d  = 1'b1;
                        state_d = SETUP;
                    end else begin
                        gcd_d = gcd_q - WIDTH'(1);
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end

            default: state_d = SETUP;
        endcase
    end

    // Post-edge value of the addressed channel; out-of-range select reads 0.
    always_comb begin
        sel_new = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (bus.select == SELW'(i)) sel_new = ch_d[i];
        end
    end

    // Display follows whatever the next state shows.
    always_comb begin
        gdiv       = (gcd_d == '0) ? WIDTH'(1) : gcd_d;
        data_out_d = data_out_q;
        case (state_d)
            SETUP:   data_out_d = sel_new;
            CALC:    if (state_q == SETUP) data_out_d = sel_new;
            SHOW:    data_out_d = (gcd_d == '0) ? '0 : sel_new / gdiv;
            COUNT:   data_out_d = gcd_d;
            default: data_out_d = data_out_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SETUP;
            for (int i = 0; i < int'(CHANNELS); i++) ch_q[i] <= '0;
            gcd_q      <= '0;
            cand_q     <= '0;
            tick_q     <= '0;
            data_out_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            add_h      <= 1'b0;
            sub_h      <= 1'b0;
            next_h     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            gcd_q      <= gcd_d;
            cand_q     <= cand_d;
            tick_q     <= tick_d;
            data_out_q <= data_out_d;
            busy_q     <= (state_d == CALC);
            done_q     <= done_d;
            add_h      <= bus.add;
            sub_h      <= bus.sub;
            next_h     <= bus.next;
        end
    end

endmodule

// File: tb/tb_gcd_countdown_n.sv
// Directed bench for gcd_countdown_n with RADIX=10, 4 channels, TICK=4, 3-bit select.
module tb_gcd_countdown_n;

    localparam int unsigned CH = 4;
    localparam int unsigned W  = 4;
    localparam int unsigned R  = 10;
    localparam int unsigned TK = 4;
    localparam int unsigned SW = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    gcd_countdown_n_if #(.WIDTH(W), .SELW(SW)) bus ();

    gcd_countdown_n #(
        .CHANNELS(CH), .WIDTH(W), .RADIX(R), .TICK(TK), .SELW(SW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-edge pulse on add(0)/sub(1)/next(2), preceded by a release cycle.
    task automatic press(input int which);
        step();
        if (which == 0) bus.add = 1'b1;
        else if (which == 1) bus.sub = 1'b1;
        else bus.next = 1'b1;
        step();
        bus.add  = 1'b0;
        bus.sub  = 1'b0;
        bus.next = 1'b0;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        bus.select  = '0;
        bus.add     = 1'b0;
        bus.sub     = 1'b0;
        bus.next    = 1'b0;
        bus.data_in = '0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic load4(input int a, input int b, input int c, input int d);
        int v [4];
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.select  = 3'(i);
            bus.data_in = 4'(v[i]);
            press(0);
        end
    endtask

    task automatic wait_calc(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            n++;
            step();
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.data_out !== 4'd0) begin failures++; $display("FAIL reset_data_out got=%0d exp=0", bus.data_out); end
        checks++; if (bus.state_out !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", bus.state_out); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    endtask

    task automatic test_edit();
        do_reset();
        bus.select = 3'd0;
        bus.data_in = 4'd8; press(0);
        checks++; if (bus.data_out !== 4'd8) begin failures++; $display("FAIL add8 got=%0d exp=8", bus.data_out); end
        bus.data_in = 4'd5; press(0);
        checks++; if (bus.data_out !== 4'd3) begin failures++; $display("FAIL add5_wrap got=%0d exp=3", bus.data_out); end
        bus.data_in = 4'd9; press(1);
        checks++; if (bus.data_out !== 4'd4) begin failures++; $display("FAIL sub9_wrap got=%0d exp=4", bus.data_out); end
        // held button: single increment
        step();
        bus.data_in = 4'd1;
        bus.add = 1'b1;
        repeat (10) step();
        bus.add = 1'b0;
        step();
        checks++; if (bus.data_out !== 4'd5) begin failures++; $display("FAIL hold_add got=%0d exp=5", bus.data_out); end
        // coincident add and sub
        bus.data_in = 4'd2;
        bus.add = 1'b1; bus.sub = 1'b1;
        step();
        bus.add = 1'b0; bus.sub = 1'b0;
        step();
        checks++; if (bus.data_out !== 4'd5) begin failures++; $display("FAIL add_sub_same got=%0d exp=5", bus.data_out); end
        // out-of-range select
        bus.select = 3'd5; bus.data_in = 4'd3;
        step();
        checks++; if (bus.data_out !== 4'd0) begin failures++; $display("FAIL sel5_read got=%0d exp=0", bus.data_out); end
        press(0);
        checks++; if (bus.data_out !== 4'd0) begin failures++; $display("FAIL sel5_add got=%0d exp=0", bus.data_out); end
        bus.select = 3'd0; step();
        checks++; if (bus.data_out !== 4'd5) begin failures++; $display("FAIL sel5_nowrite_ch0 got=%0d exp=5", bus.data_out); end
        bus.select = 3'd1; step();
        checks++; if (bus.data_out !== 4'd0) begin failures++; $display("FAIL sel5_nowrite_ch1 got=%0d exp=0", bus.data_out); end
    endtask

    task automatic test_gcd();
        int n;
        load4(6, 9, 3, 0);
        bus.select = 3'd1;
        press(2);
        wait_calc(n);
        checks++; if (n !== 7) begin failures++; $display("FAIL gcd_busy_cycles got=%0d exp=7", n); end
        checks++; if (bus.state_out !== 2'd2) begin failures++; $display("FAIL gcd_state got=%0d exp=2", bus.state_out); end
        step();
        checks++; if (bus.data_out !== 4'd3) begin failures++; $display("FAIL gcd_show_ch1 got=%0d exp=3", bus.data_out); end
        bus.select = 3'd0; step();
        checks++; if (bus.data_out !== 4'd2) begin failures++; $display("FAIL gcd_show_ch0 got=%0d exp=2", bus.data_out); end
    endtask

    // Runs from SHOW with gcd=3 left by test_gcd.
    task automatic test_countdown();
        int exp;
        bus.select = 3'd1;
        press(2);
        for (int k = 0; k < 12; k++) begin
            exp = 3 - k / 4;
            checks++;
            if (bus.data_out !== 4'(exp) || bus.done !== 1'b0) begin
                failures++;
                $display("FAIL countdown_k%0d got=%0d done=%b exp=%0d done=0", k, bus.data_out, bus.done, exp);
            end
            step();
        end
        checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL countdown_done got=%b exp=1", bus.done); end
        checks++; if (bus.state_out !== 2'd0) begin failures++; $display("FAIL countdown_state got=%0d exp=0", bus.state_out); end
        checks++; if (bus.data_out !== 4'd9) begin failures++; $display("FAIL countdown_disp got=%0d exp=9", bus.data_out); end
        step();
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL countdown_done_pulse got=%b exp=0", bus.done); end
    endtask

    task automatic test_all_zero();
        int n;
        do_reset();
        press(2);
        wait_calc(n);
        checks++; if (n !== 1) begin failures++; $display("FAIL zero_busy_cycles got=%0d exp=1", n); end
        checks++; if (bus.state_out !== 2'd2 || bus.data_out !== 4'd0) begin failures++; $display("FAIL zero_show state=%0d data=%0d exp=2/0", bus.state_out, bus.data_out); end
        press(2);
        checks++; if (bus.state_out !== 2'd0 || bus.done !== 1'b0) begin failures++; $display("FAIL zero_exit state=%0d done=%b exp=0/0", bus.state_out, bus.done); end
        step();
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL zero_no_done got=%b exp=0", bus.done); end
    endtask

    task automatic test_early_exit();
        int n;
        load4(6, 9, 3, 0);
        bus.select = 3'd0;
        press(2);
        wait_calc(n);
        press(2);
        n = 0;
        while (bus.data_out !== 4'd2 && n < 20) begin n++; step(); end
        press(2);
        checks++; if (bus.state_out !== 2'd3 || bus.data_out !== 4'd2) begin failures++; $display("FAIL early_at2 state=%0d data=%0d exp=3/2", bus.state_out, bus.data_out); end
        n = 0;
        while (bus.state_out !== 2'd0 && n < 60) begin n++; step(); end
        checks++; if (bus.state_out !== 2'd0) begin failures++; $display("FAIL early_finish state=%0d exp=0", bus.state_out); end
        press(2);
        wait_calc(n);
        press(2);
        checks++; if (bus.data_out !== 4'd3) begin failures++; $display("FAIL early_rerun_disp got=%0d exp=3", bus.data_out); end
        press(2);
        checks++; if (bus.state_out !== 2'd0 || bus.done !== 1'b0) begin failures++; $display("FAIL early_at3 state=%0d done=%b exp=0/0", bus.state_out, bus.done); end
        checks++; if (bus.data_out !== 4'd6) begin failures++; $display("FAIL early_at3_disp got=%0d exp=6", bus.data_out); end
    endtask

    task automatic test_apply();
        int n;
        load4(6, 9, 3, 0);
        bus.select = 3'd0;
        press(2);
        wait_calc(n);
        press(0);
        checks++; if (bus.state_out !== 2'd2 || bus.data_out !== 4'd2) begin failures++; $display("FAIL apply_ch0 state=%0d data=%0d exp=2/2", bus.state_out, bus.data_out); end
        bus.select = 3'd1; step();
        checks++; if (bus.data_out !== 4'd3) begin failures++; $display("FAIL apply_ch1 got=%0d exp=3", bus.data_out); end
        bus.select = 3'd2; step();
        checks++; if (bus.data_out !== 4'd1) begin failures++; $display("FAIL apply_ch2 got=%0d exp=1", bus.data_out); end
        bus.select = 3'd3; step();
        checks++; if (bus.data_out !== 4'd0) begin failures++; $display("FAIL apply_ch3 got=%0d exp=0", bus.data_out); end
        bus.select = 3'd1;
        bus.data_in = 4'd1;
        press(1);
        checks++; if (bus.state_out !== 2'd2 || bus.data_out !== 4'd3) begin failures++; $display("FAIL show_sub_ignored state=%0d data=%0d exp=2/3", bus.state_out, bus.data_out); end
        press(2);
        checks++; if (bus.data_out !== 4'd1) begin failures++; $display("FAIL apply_count got=%0d exp=1", bus.data_out); end
        repeat (4) step();
        checks++; if (bus.done !== 1'b1 || bus.state_out !== 2'd0 || bus.data_out !== 4'd3) begin failures++; $display("FAIL apply_done done=%b state=%0d data=%0d exp=1/0/3", bus.done, bus.state_out, bus.data_out); end
    endtask

    task automatic test_reset_mid_count();
        int n;
        load4(6, 9, 3, 0);
        press(2);
        wait_calc(n);
        press(2);
        step();
        checks++; if (bus.state_out !== 2'd3) begin failures++; $display("FAIL midrst_precond state=%0d exp=3", bus.state_out); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.data_out !== 4'd0 || bus.state_out !== 2'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL midrst_outputs data=%0d state=%0d busy=%b done=%b exp=0/0/0/0", bus.data_out, bus.state_out, bus.busy, bus.done);
        end
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            bus.select = 3'(i);
            step();
            checks++; if (bus.data_out !== 4'd0) begin failures++; $display("FAIL midrst_ch%0d got=%0d exp=0", i, bus.data_out); end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_edit();
        test_gcd();
        test_countdown();
        test_all_zero();
        test_early_exit();
        test_apply();
        test_reset_mid_count();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
